// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD controller: FSM states, special
// command codes, the HD44780 power-up init ROM and status word bit positions.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_LOAD,
        ST_SETUP,
        ST_ENH,
        ST_HOLD,
        ST_EXEC,
        ST_IDLE
    } lcd_state_e;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

    localparam int INIT_LEN   = 7;
    localparam int INIT_IDX_W = 3;

    localparam int STAT_BUSY = 0;
    localparam int STAT_INIT = 1;
    localparam int STAT_OVF  = 2;

    // 8-bit interface, 2 lines, display off, clear, entry mode, display on.
    function automatic logic [7:0] init_rom(input logic [INIT_IDX_W-1:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: init_rom = 8'h38;
            3'd3:             init_rom = 8'h08;
            3'd4:             init_rom = 8'h01;
            3'd5:             init_rom = 8'h06;
            default:          init_rom = 8'h0C;
        endcase
    endfunction

    // Clear and home need the long execution wait; everything else is short.
    function automatic logic is_long_exec(input logic rs, input logic [7:0] code);
        is_long_exec = !rs && ((code == LCD_CMD_CLEAR) || (code == LCD_CMD_HOME));
    endfunction

    function automatic int max_int(input int a, input int b);
        max_int = (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small synchronous FIFO holding {RS, byte} commands between the store path
// and the LCD timing FSM. Read data is the head entry, valid whenever !empty.
module lcd_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign full     = (count_reg == CNT_W'(DEPTH));
    assign empty    = (count_reg == '0);
    assign pop_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 8-bit character-LCD controller: queues CPU stores, runs the
// power-up init sequence, then replays commands with bus timing on the pins.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PWRUP_CYC  = 750000,
    parameter int SETUP_CYC  = 2,
    parameter int EN_CYC     = 12,
    parameter int HOLD_CYC   = 1,
    parameter int CMD_CYC    = 2000,
    parameter int CLR_CYC    = 82000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wr_stb,
    input  logic [31:0] i_wr_data,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_busy,
    output logic        o_init_done,
    output logic        o_overflow,
    output logic [31:0] o_status
);

    localparam int MAX_CYC = max_int(max_int(max_int(PWRUP_CYC, SETUP_CYC),
                                             max_int(EN_CYC, HOLD_CYC)),
                                     max_int(CMD_CYC, CLR_CYC));
    localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LD      = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LD     = CNT_W'(CMD_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LD     = CNT_W'(CLR_CYC - 1);
    localparam logic [INIT_IDX_W-1:0] INIT_LAST = INIT_IDX_W'(INIT_LEN - 1);

    lcd_state_e            state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [INIT_IDX_W-1:0] idx_reg, idx_next;
    logic                  init_done_reg, init_done_next;
    logic [8:0]            cmd_reg, cmd_next;
    logic                  ovf_reg;
    logic                  on_reg;

    logic                  fifo_pop;
    logic [8:0]            fifo_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  busy;
    logic                  unused_wr_bits;

    assign unused_wr_bits = ^i_wr_data[31:9];

    lcd_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_reset),
        .push      (i_wr_stb),
        .push_data (i_wr_data[8:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_reg     <= ST_PWRUP;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            init_done_reg <= 1'b0;
            cmd_reg       <= '0;
            ovf_reg       <= 1'b0;
            on_reg        <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            idx_reg       <= idx_next;
            init_done_reg <= init_done_next;
            cmd_reg       <= cmd_next;
            on_reg        <= 1'b1;
            if (i_wr_stb && fifo_full) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    // Timed states load N-1 on entry and leave when the counter reaches 0;
    // PWRUP instead counts up from the reset value of 0.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = (cnt_reg != '0) ? cnt_reg - 1'b1 : '0;
        idx_next       = idx_reg;
        init_done_next = init_done_reg;
        cmd_next       = cmd_reg;
        fifo_pop       = 1'b0;

        case (state_reg)
            ST_PWRUP: begin
                if (cnt_reg == PWRUP_LAST) begin
                    state_next = ST_LOAD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_LOAD: begin
                if (!init_done_reg) begin
                    cmd_next = {1'b0, init_rom(idx_reg)};
                end else begin
                    cmd_next = fifo_data;
                    fifo_pop = 1'b1;
                end
                state_next = ST_SETUP;
                cnt_next   = SETUP_LD;
            end
            ST_SETUP: begin
                if (cnt_reg == '0) begin
                    state_next = ST_ENH;
                    cnt_next   = EN_LD;
                end
            end
            ST_ENH: begin
                if (cnt_reg == '0) begin
                    state_next = ST_HOLD;
                    cnt_next   = HOLD_LD;
                end
            end
            ST_HOLD: begin
                if (cnt_reg == '0) begin
                    state_next = ST_EXEC;
                    cnt_next   = is_long_exec(cmd_reg[8], cmd_reg[7:0]) ? CLR_LD : CMD_LD;
                end
            end
            ST_EXEC: begin
                if (cnt_reg == '0) begin
                    if (!init_done_reg) begin
                        if (idx_reg == INIT_LAST) begin
                            init_done_next = 1'b1;
                            state_next     = ST_IDLE;
                        end else begin
                            idx_next   = idx_reg + 1'b1;
                            state_next = ST_LOAD;
                        end
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                // A strobe arriving now is in the FIFO by the time LOAD pops.
                if (!fifo_empty || i_wr_stb) begin
                    state_next = ST_LOAD;
                end
            end
            default: begin
                state_next = ST_PWRUP;
                cnt_next   = '0;
            end
        endcase
    end

    assign busy = !init_done_reg || (state_reg != ST_IDLE) || !fifo_empty;

    assign o_lcd_data  = cmd_reg[7:0];
    assign o_lcd_rs    = cmd_reg[8];
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_en    = (state_reg == ST_ENH);
    assign o_lcd_on    = on_reg;
    assign o_busy      = busy;
    assign o_init_done = init_done_reg;
    assign o_overflow  = ovf_reg;

    always_comb begin
        o_status            = '0;
        o_status[STAT_BUSY] = busy;
        o_status[STAT_INIT] = init_done_reg;
        o_status[STAT_OVF]  = ovf_reg;
    end

endmodule
